// File: rtl/count_range_mon_pkg.sv
// Shared types and step arithmetic for the range counter monitor.
// Helpers work on a wide word so any W up to 32 can zero-extend into them.
package count_range_mon_pkg;

    localparam int DEF_W  = 8;
    localparam int DEF_PW = 16;
    localparam int DEF_SW = 8;

    localparam int FW = 32;

    typedef logic [FW-1:0] word_t;
    typedef logic [FW:0]   wide_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef struct packed {
        logic tc;
        logic wrap;
        logic step;
        logic range;
        logic cfg;
    } flags_t;

    // One extra bit keeps last+1 from folding back onto first at the top of the range.
    function automatic wide_t next_up(input word_t prev, input word_t first, input word_t last);
        if (prev == last) begin
            return wide_t'(first);
        end
        return wide_t'(prev) + wide_t'(1);
    endfunction

    function automatic wide_t next_dn(input word_t prev, input word_t first, input word_t last);
        if (prev == first) begin
            return wide_t'(last);
        end
        return wide_t'(prev) - wide_t'(1);
    endfunction

    function automatic logic in_range(input word_t v, input word_t first, input word_t last);
        return (v >= first) && (v <= last);
    endfunction

endpackage

// File: rtl/count_range_mon_slot.sv
// Single-entry valid/ready holding register for period records.
// A push into an occupied, undrained slot is dropped and latches a sticky overflow.
module count_range_mon_slot
    import count_range_mon_pkg::*;
#(
    parameter int DW = DEF_PW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_ovf
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_ovf;

    logic w_drain;
    logic w_accept;

    assign w_drain  = r_valid && i_ready;
    assign w_accept = !r_valid || w_drain;

    // Held data stays frozen until the consumer takes it; a refill may land in the drain cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (i_push && w_accept) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
            if (i_push && !w_accept) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/count_range_sweep_monitor.sv
// Checker for the range up/down load counter: flags bad steps, range and config faults,
// counts wraps and reports wrap-to-wrap sweep periods through a one-entry record slot.
module count_range_sweep_monitor
    import count_range_mon_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int PW = DEF_PW,
    parameter int SW = DEF_SW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [W-1:0]  i_count,
    input  logic [W-1:0]  i_first,
    input  logic [W-1:0]  i_last,
    input  logic          i_u_d,
    input  logic          i_load,
    output logic          o_tc_pulse,
    output logic          o_wrap_pulse,
    output logic          o_err_step,
    output logic          o_err_range,
    output logic          o_err_cfg,
    output logic [SW-1:0] o_sweep_cnt,
    output logic [PW-1:0] o_period,
    output logic          o_period_valid,
    input  logic          i_period_ready,
    output logic          o_period_ovf
);

    logic [W-1:0]  r_prev;
    dir_e          r_ud_q;
    logic          r_ld_q;
    logic          r_prev_valid;
    flags_t        r_flags;
    logic [SW-1:0] r_sweep;
    logic [PW-1:0] r_period_cnt;
    logic          r_first_wrap_seen;

    logic   w_cfg_bad;
    logic   w_chk_en;
    logic   w_legal;
    logic   w_at_term;
    wide_t  w_expect;
    flags_t w_flags;
    logic   w_push;

    // The counter's current value was decided by last cycle's direction and load,
    // so every step check is made against the registered controls.
    always_comb begin
        w_cfg_bad = 1'b0;
        w_chk_en  = 1'b0;
        w_expect  = '0;
        w_legal   = 1'b0;
        w_at_term = 1'b0;
        w_flags   = '0;

        w_cfg_bad = i_first > i_last;
        w_chk_en  = r_prev_valid && !r_ld_q && !w_cfg_bad &&
                    in_range(word_t'(r_prev), word_t'(i_first), word_t'(i_last));

        if (r_ud_q == DIR_UP) begin
            w_expect  = next_up(word_t'(r_prev), word_t'(i_first), word_t'(i_last));
            w_at_term = (r_prev == i_last);
        end else begin
            w_expect  = next_dn(word_t'(r_prev), word_t'(i_first), word_t'(i_last));
            w_at_term = (r_prev == i_first);
        end
        w_legal = (wide_t'(i_count) == w_expect);

        w_flags.step  = w_chk_en && !w_legal;
        w_flags.wrap  = w_chk_en && w_legal && w_at_term;
        w_flags.tc    = w_chk_en && (i_count == ((r_ud_q == DIR_UP) ? i_last : i_first));
        w_flags.range = r_prev_valid && !w_cfg_bad &&
                        !in_range(word_t'(i_count), word_t'(i_first), word_t'(i_last));
        w_flags.cfg   = w_cfg_bad;
    end

    assign w_push = w_flags.wrap && r_first_wrap_seen;

    // The period counter restarts at 1 on each wrap so its value at the next wrap is the distance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev            <= '0;
            r_ud_q            <= DIR_DOWN;
            r_ld_q            <= 1'b0;
            r_prev_valid      <= 1'b0;
            r_flags           <= '0;
            r_sweep           <= '0;
            r_period_cnt      <= '0;
            r_first_wrap_seen <= 1'b0;
        end else begin
            r_prev       <= i_count;
            r_ud_q       <= dir_e'(i_u_d);
            r_ld_q       <= i_load;
            r_prev_valid <= 1'b1;
            r_flags      <= w_flags;
            if (w_flags.wrap) begin
                r_sweep           <= r_sweep + SW'(1);
                r_period_cnt      <= PW'(1);
                r_first_wrap_seen <= 1'b1;
            end else if (r_period_cnt != {PW{1'b1}}) begin
                r_period_cnt <= r_period_cnt + PW'(1);
            end
        end
    end

    count_range_mon_slot #(
        .DW(PW)
    ) u_slot (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (r_period_cnt),
        .i_ready (i_period_ready),
        .o_valid (o_period_valid),
        .o_data  (o_period),
        .o_ovf   (o_period_ovf)
    );

    assign o_tc_pulse   = r_flags.tc;
    assign o_wrap_pulse = r_flags.wrap;
    assign o_err_step   = r_flags.step;
    assign o_err_range  = r_flags.range;
    assign o_err_cfg    = r_flags.cfg;
    assign o_sweep_cnt  = r_sweep;

endmodule

// File: tb/tb_count_range_sweep_monitor.sv
// Bench for count_range_sweep_monitor: directed scenarios plus a randomized run
// scored against a behavioural model of the monitor's rules.
module tb_count_range_sweep_monitor;

    localparam int W  = 8;
    localparam int PW = 16;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  count;
    logic [W-1:0]  first;
    logic [W-1:0]  last;
    logic          u_d;
    logic          load;
    logic          period_ready;
    logic          tc_pulse;
    logic          wrap_pulse;
    logic          err_step;
    logic          err_range;
    logic          err_cfg;
    logic [SW-1:0] sweep_cnt;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          period_ovf;
    logic [4:0]    flags;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: last sample, registered controls, wraps, period and slot contents.
    int   m_prev, m_pv, m_udq, m_ldq, m_sweep, m_per, m_seen, m_sv, m_sdata, m_ovf;
    logic e_tc, e_wrap, e_step, e_range, e_cfg;

    always #5 clk = ~clk;

    assign flags = {tc_pulse, wrap_pulse, err_step, err_range, err_cfg};

    count_range_sweep_monitor #(
        .W(W),
        .PW(PW),
        .SW(SW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_count        (count),
        .i_first        (first),
        .i_last         (last),
        .i_u_d          (u_d),
        .i_load         (load),
        .o_tc_pulse     (tc_pulse),
        .o_wrap_pulse   (wrap_pulse),
        .o_err_step     (err_step),
        .o_err_range    (err_range),
        .o_err_cfg      (err_cfg),
        .o_sweep_cnt    (sweep_cnt),
        .o_period       (period),
        .o_period_valid (period_valid),
        .i_period_ready (period_ready),
        .o_period_ovf   (period_ovf)
    );

    // Applies one sample, lets the monitor register it, then advances the model.
    task automatic drive(input int c, input int f, input int l, input int ud,
                         input int ld, input int rdy, input int rs);
        int  nxt_ok;
        int  wrapc;
        int  en;
        int  cfgbad;
        int  drain;
        count        = c[7:0];
        first        = f[7:0];
        last         = l[7:0];
        u_d          = ud[0];
        load         = ld[0];
        period_ready = rdy[0];
        rst          = rs[0];
        @(posedge clk);
        #1;
        if (rs != 0) begin
            m_prev = 0; m_pv = 0; m_udq = 0; m_ldq = 0; m_sweep = 0;
            m_per = 0; m_seen = 0; m_sv = 0; m_sdata = 0; m_ovf = 0;
            e_tc = 0; e_wrap = 0; e_step = 0; e_range = 0; e_cfg = 0;
        end else begin
            cfgbad = (f > l);
            en = (m_pv != 0) && (m_ldq == 0) && !cfgbad && (m_prev >= f) && (m_prev <= l);
            if (m_udq != 0) begin
                nxt_ok = (m_prev < l) && (c == m_prev + 1);
                wrapc  = (m_prev == l) && (c == f);
            end else begin
                nxt_ok = (m_prev > f) && (c == m_prev - 1);
                wrapc  = (m_prev == f) && (c == l);
            end
            e_step  = en && !(nxt_ok || wrapc);
            e_wrap  = en && wrapc;
            e_tc    = en && (c == ((m_udq != 0) ? l : f));
            e_range = (m_pv != 0) && !cfgbad && ((c < f) || (c > l));
            e_cfg   = cfgbad;
            drain = (m_sv != 0) && (rdy != 0);
            if (e_wrap && m_seen != 0) begin
                if (m_sv == 0 || drain) begin
                    m_sdata = m_per;
                    m_sv = 1;
                end else begin
                    m_ovf = 1;
                end
            end else if (drain) begin
                m_sv = 0;
            end
            if (e_wrap) begin
                m_seen = 1;
                m_per = 1;
                m_sweep = (m_sweep + 1) % 256;
            end else if (m_per < 65535) begin
                m_per = m_per + 1;
            end
            m_prev = c; m_udq = ud; m_ldq = ld; m_pv = 1;
        end
    endtask

    task automatic test_reset();
        drive(0, 11, 25, 1, 0, 1, 1);
        drive(0, 11, 25, 1, 0, 1, 1);
        tests_run++;
        if (flags !== 5'b00000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected %b", flags, 5'b00000);
        end
        tests_run++;
        if (sweep_cnt !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_sweep: got %0d expected 0", sweep_cnt);
        end
        tests_run++;
        if (period_valid !== 1'b0 || period_ovf !== 1'b0 || period !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_slot: got valid=%b ovf=%b period=%0d expected 0/0/0",
                     period_valid, period_ovf, period);
        end
    endtask

    task automatic test_up_sweep();
        logic [4:0] exp_f;
        int recs = 0;
        for (int pass = 0; pass < 3; pass++) begin
            for (int v = 11; v <= 25; v++) begin
                drive(v, 11, 25, 1, 0, 1, 0);
                exp_f = {(v == 25), (v == 11 && pass > 0), 3'b000};
                tests_run++;
                if (flags !== exp_f) begin
                    tests_failed++;
                    $display("[TB] FAIL up_flags v=%0d: got %b expected %b", v, flags, exp_f);
                end
                if (period_valid === 1'b1) begin
                    recs++;
                    tests_run++;
                    if (period !== 16'd15) begin
                        tests_failed++;
                        $display("[TB] FAIL up_period: got %0d expected 15", period);
                    end
                end
            end
        end
        drive(11, 11, 25, 1, 0, 1, 0);
        tests_run++;
        if (flags !== 5'b01000) begin
            tests_failed++;
            $display("[TB] FAIL up_last_wrap: got %b expected %b", flags, 5'b01000);
        end
        if (period_valid === 1'b1) begin
            recs++;
            tests_run++;
            if (period !== 16'd15) begin
                tests_failed++;
                $display("[TB] FAIL up_period_last: got %0d expected 15", period);
            end
        end
        tests_run++;
        if (sweep_cnt !== 8'd3) begin
            tests_failed++;
            $display("[TB] FAIL up_sweep_cnt: got %0d expected 3", sweep_cnt);
        end
        tests_run++;
        if (recs != 2) begin
            tests_failed++;
            $display("[TB] FAIL up_record_count: got %0d expected 2", recs);
        end
    endtask

    task automatic test_down_sweep();
        logic [4:0] exp_f;
        for (int v = 12; v <= 18; v++) begin
            drive(v, 11, 25, (v == 18) ? 0 : 1, 0, 1, 0);
            tests_run++;
            if (flags !== 5'b00000) begin
                tests_failed++;
                $display("[TB] FAIL dn_climb v=%0d: got %b expected 00000", v, flags);
            end
        end
        for (int v = 17; v >= 11; v--) begin
            drive(v, 11, 25, 0, 0, 1, 0);
            exp_f = {(v == 11), 4'b0000};
            tests_run++;
            if (flags !== exp_f) begin
                tests_failed++;
                $display("[TB] FAIL dn_flags v=%0d: got %b expected %b", v, flags, exp_f);
            end
        end
        drive(25, 11, 25, 0, 0, 1, 0);
        tests_run++;
        if (flags !== 5'b01000 || sweep_cnt !== 8'd4) begin
            tests_failed++;
            $display("[TB] FAIL dn_wrap: got flags=%b sweep=%0d expected 01000/4", flags, sweep_cnt);
        end
        tests_run++;
        if (period_valid !== 1'b1 || period !== 16'd15) begin
            tests_failed++;
            $display("[TB] FAIL dn_period: got valid=%b period=%0d expected 1/15", period_valid, period);
        end
    endtask

    task automatic test_faults();
        int         seq_c [11] = '{24, 14, 16, 17, 30, 12, 13, 13, 50, 14, 15};
        int         seq_f [11] = '{11, 11, 11, 11, 11, 11, 11, 20, 20, 11, 11};
        int         seq_l [11] = '{25, 25, 25, 25, 25, 25, 25, 10, 10, 25, 25};
        int         seq_ld[11] = '{1,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0};
        logic [4:0] seq_e [11] = '{5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00110, 5'b00000,
                                   5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
        for (int i = 0; i < 11; i++) begin
            drive(seq_c[i], seq_f[i], seq_l[i], 1, seq_ld[i], 1, 0);
            tests_run++;
            if (flags !== seq_e[i]) begin
                tests_failed++;
                $display("[TB] FAIL fault_%0d count=%0d: got %b expected %b", i, seq_c[i], flags, seq_e[i]);
            end
        end
    endtask

    task automatic test_load();
        int seq_c [7] = '{16, 15, 14, 13, 22, 23, 24};
        int seq_ud[7] = '{0,  0,  0,  1,  1,  1,  1};
        int seq_ld[7] = '{0,  0,  0,  1,  0,  0,  0};
        for (int i = 0; i < 7; i++) begin
            drive(seq_c[i], 11, 25, seq_ud[i], seq_ld[i], 1, 0);
            tests_run++;
            if (flags !== 5'b00000) begin
                tests_failed++;
                $display("[TB] FAIL load_%0d count=%0d: got %b expected 00000", i, seq_c[i], flags);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(25, 11, 25, 1, 0, 0, 0);
        drive(11, 11, 25, 1, 0, 0, 0);
        tests_run++;
        if (period_valid !== 1'b1 || period !== 16'd20 || period_ovf !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hs_first: got valid=%b period=%0d ovf=%b expected 1/20/0",
                     period_valid, period, period_ovf);
        end
        for (int k = 0; k < 2; k++) begin
            for (int v = 12; v <= 26; v++) begin
                drive((v == 26) ? 11 : v, 11, 25, 1, 0, 0, 0);
                tests_run++;
                if (period_valid !== 1'b1 || period !== 16'd20) begin
                    tests_failed++;
                    $display("[TB] FAIL hs_hold: got valid=%b period=%0d expected 1/20", period_valid, period);
                end
            end
        end
        tests_run++;
        if (period_ovf !== 1'b1 || sweep_cnt !== 8'd7) begin
            tests_failed++;
            $display("[TB] FAIL hs_ovf: got ovf=%b sweep=%0d expected 1/7", period_ovf, sweep_cnt);
        end
        drive(12, 11, 25, 1, 0, 1, 0);
        tests_run++;
        if (period_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hs_drain: got valid=%b expected 0", period_valid);
        end
        for (int v = 13; v <= 26; v++) begin
            drive((v == 26) ? 11 : v, 11, 25, 1, 0, 1, 0);
        end
        tests_run++;
        if (period_valid !== 1'b1 || period !== 16'd15 || period_ovf !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL hs_next: got valid=%b period=%0d ovf=%b expected 1/15/1",
                     period_valid, period, period_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int         seq_c[4] = '{5, 6, 11, 12};
        logic [4:0] seq_e[4] = '{5'b00000, 5'b00010, 5'b00000, 5'b00000};
        for (int v = 12; v <= 18; v++) begin
            drive(v, 11, 25, 1, 0, 1, 0);
        end
        drive(19, 11, 25, 1, 0, 1, 1);
        tests_run++;
        if (flags !== 5'b00000 || sweep_cnt !== 8'd0 || period_valid !== 1'b0 || period_ovf !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: got flags=%b sweep=%0d valid=%b ovf=%b expected all 0",
                     flags, sweep_cnt, period_valid, period_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            drive(seq_c[i], 11, 25, 1, 0, 1, 0);
            tests_run++;
            if (flags !== seq_e[i]) begin
                tests_failed++;
                $display("[TB] FAIL mid_after_%0d: got %b expected %b", i, flags, seq_e[i]);
            end
        end
    endtask

    task automatic test_random();
        int f, l, gc, gud, gld, rdy, rs, nxt, mode;
        logic [4:0] exp_f;
        drive(0, 0, 0, 1, 0, 1, 1);
        for (int seg = 0; seg < 12; seg++) begin
            mode = $urandom_range(0, 5);
            case (mode)
                0: begin f = 0; l = 255; end
                1: begin f = $urandom_range(0, 255); l = f; end
                2: begin f = $urandom_range(1, 255); l = $urandom_range(0, f - 1); end
                default: begin
                    f = $urandom_range(0, 200);
                    l = f + $urandom_range(1, 40);
                    if (l > 255) l = 255;
                end
            endcase
            gc = f; gud = $urandom_range(0, 1); gld = 1;
            drive(gc, f, l, gud, gld, 1, 0);
            for (int n = 0; n < 250; n++) begin
                if (gld != 0) nxt = (f <= l) ? $urandom_range(f, l) : $urandom_range(0, 255);
                else if (gud != 0) nxt = (gc == l) ? f : gc + 1;
                else nxt = (gc == f) ? l : gc - 1;
                nxt = nxt & 255;
                if ($urandom_range(0, 99) < 3) nxt = $urandom_range(0, 255);
                if ($urandom_range(0, 99) < 8) gud = 1 - gud;
                gld = ($urandom_range(0, 99) < 3) ? 1 : 0;
                rdy = ($urandom_range(0, 99) < 60) ? 1 : 0;
                rs  = ($urandom_range(0, 199) == 0) ? 1 : 0;
                gc = nxt;
                drive(gc, f, l, gud, gld, rdy, rs);
                exp_f = {e_tc, e_wrap, e_step, e_range, e_cfg};
                tests_run++;
                if (flags !== exp_f) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_flags f=%0d l=%0d c=%0d: got %b expected %b", f, l, gc, flags, exp_f);
                end
                tests_run++;
                if (sweep_cnt !== m_sweep[7:0]) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_sweep: got %0d expected %0d", sweep_cnt, m_sweep);
                end
                tests_run++;
                if (period_valid !== m_sv[0] || period_ovf !== m_ovf[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_slot: got valid=%b ovf=%b expected %0d/%0d",
                             period_valid, period_ovf, m_sv, m_ovf);
                end
                if (m_sv != 0) begin
                    tests_run++;
                    if (period !== m_sdata[15:0]) begin
                        tests_failed++;
                        $display("[TB] FAIL rnd_period: got %0d expected %0d", period, m_sdata);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_sweep();
        test_down_sweep();
        test_faults();
        test_load();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/count_range_sweep_monitor.md
Name: count_range_sweep_monitor

Overview:
Downstream checker/measurement stage for the range up/down load counter. It samples the counter's `count` output together with the same `first`, `last`, `u_d` and `load` controls. Per cycle it flags illegal steps, out-of-range values, terminal-count hits and wrap events. It measures sweep period (cycles between wraps) and delivers each period as a record on a valid/ready output.

Parameters:
W, 8, width of count/first/last
PW, 16, width of period measurement (saturating)
SW, 8, width of sweep counter (wraps modulo 2^SW)

Ports:
clk  input  1  rising-edge clock, shared with counter
rst  input  1  synchronous, active-high reset
count  input  W  counter output under observation
first  input  W  range lower bound (same value driven to counter)
last  input  W  range upper bound
u_d  input  1  direction driven to counter (1=up, 0=down)
load  input  1  load request driven to counter
tc_pulse  output  1  one-cycle pulse: observed count equals terminal value (last if up, first if down)
wrap_pulse  output  1  one-cycle pulse: legal wrap observed (last->first up, first->last down)
err_step  output  1  one-cycle pulse: illegal transition
err_range  output  1  one-cycle pulse: count outside [first,last]
err_cfg  output  1  level: first > last; all checks suppressed
sweep_cnt  output  SW  number of wraps since reset
period  output  PW  cycles between consecutive wraps
period_valid  output  1  record available
period_ready  input  1  consumer accepts record
period_ovf  output  1  sticky: a record was dropped because the slot was full

Behaviour:
- Reset: all outputs 0; prev_valid=0; period counter=0; first_wrap_seen=0.
- Each posedge, the block registers prev=count, ud_q=u_d, ld_q=load and prev_valid=1. Checks compare the current count against prev using ud_q and ld_q, because the counter's next value depends on the previous-cycle controls.
- All pulse and level outputs are registered and appear on the cycle after the count sample that caused them (latency 1).
- Check enable requires all of the following; otherwise err_step, tc_pulse and wrap_pulse are 0:
  - prev_valid=1
  - ld_q=0
  - err_cfg=0
  - prev was itself within [first,last]
- Legal step when ud_q=1: count==prev+1 with prev<last, or prev==last with count==first.
- Legal step when ud_q=0: count==prev-1 with prev>first, or prev==first with count==last.
- Any other transition while checks are enabled raises err_step.
- Arithmetic rules:
  - prev±1 is computed at W+1 bits, so last=2^W-1 and first=0 do not alias.
  - first==last: count==prev==first is a legal wrap every cycle.
- err_range: asserted when count<first or count>last, evaluated whenever prev_valid=1 and err_cfg=0, including during load.
- tc_pulse: asserted when count equals the terminal value for ud_q and checks are enabled.
- wrap_pulse:
  - Asserted on a legal wrap transition only.
  - sweep_cnt increments on each wrap_pulse and wraps modulo 2^SW.
- Direction change: a u_d toggle takes effect through ud_q. A reversal at an interior value is legal, since the counter simply steps the other way.
- Period measurement:
  - The period counter increments every cycle and saturates at 2^PW-1.
  - On a wrap it reloads to 1.
  - The first wrap after reset only sets first_wrap_seen and emits no record.
  - Each later wrap emits record period = counter value, i.e. the wrap-to-wrap distance in cycles. For first=11, last=25, up-counting with no stalls, period=15.
- Output slot (single entry):
  - A record is pushed when the slot is empty, or when period_valid&&period_ready in the same cycle (pass-through refill).
  - If the slot is full and not being drained, the new record is dropped, the held record is kept, and period_ovf sets.
  - period and period_valid stay stable while period_valid=1 and period_ready=0.
- period_ovf clears only on rst.
- rst mid-operation: all state clears; the first cycle after rst deassertion only primes prev, and no checks run.

Decomposition:
- Package count_range_mon_pkg holds:
  - W, PW and SW defaults.
  - Functions next_up(prev,first,last) and next_dn(prev,first,last) returning the expected value.
  - in_range(v,first,last).
- Sub-module count_range_mon_slot: one-entry valid/ready holding register with drop/overflow indication. The top level instantiates it once for the period records.

Test Plan:
- Up sweep: rst 2 cycles; first=11, last=25, u_d=1, count driven by a reference counter through 11..25 three times -> wrap_pulse on each 25->11, tc_pulse on each 25, sweep_cnt=3, two records with period=15, no errors.
- Down sweep: u_d=0 from count=18 -> 17..11 then 25 -> wrap_pulse on 11->25, tc_pulse on 11, no err_step at the reversal cycle.
- Faults: count 14->16 -> err_step for one cycle; count=30 -> err_range and err_step; next transition from 30 -> no err_step because prev was out of range; first=20, last=10 -> err_cfg=1 and no other flags.
- Load: load=1 for one cycle, count jumps 13->22 -> no err_step; err_range=0; stepping resumes from 23 cleanly.
- Handshake: period_ready=0 across 3 wraps -> first period record held stable, period_ovf=1; ready=1 -> record accepted, period_valid drops, next record is the one after the drain.
- Reset mid-sweep: rst at count=19 for 1 cycle -> all outputs 0, sweep_cnt=0, no err_step on the first post-reset sample.
